// File: rtl/addbit_serial_sequencer.sv
// Bit-serial add controller: feeds one external 1-bit full adder LSB first,
// one bit per clock, between a valid/ready operand source and result sink.
module addbit_serial_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             add_a,
    output logic             add_b,
    output logic             add_ci,
    input  logic             add_sum,
    input  logic             add_co,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == S_IDLE) && op_valid;
    assign w_last   = (r_count == LAST_BIT);

    always_comb begin
        w_next    = r_state;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        add_a     = 1'b0;
        add_b     = 1'b0;
        add_ci    = 1'b0;
        case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) w_next = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                add_a  = r_sha[0];
                add_b  = r_shb[0];
                add_ci = r_carry;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sha   <= '0;
            r_shb   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sha   <= op_a;
                r_shb   <= op_b;
                r_carry <= op_cin;
                r_count <= '0;
            end else if (r_state == S_RUN) begin
                // Sum bits enter at the MSB so bit 0 lands at res_sum[0] after WIDTH shifts.
                r_sum   <= {add_sum, r_sum[WIDTH-1:1]};
                r_carry <= add_co;
                r_sha   <= r_sha >> 1;
                r_shb   <= r_shb >> 1;
                r_count <= r_count + 1'b1;
                if (w_last) r_cout <= add_co;
            end
        end
    end

    assign res_sum  = r_sum;
    assign res_cout = r_cout;

endmodule
